// File: rtl/scan_decoder_l.sv
// Registered active-low one-hot decoder with optional auto-scan of all indices.
// A prescale counter dwells on each index and blanks every output at the start of each dwell.
module scan_decoder_l #(
   parameter int SEL_W    = 2,
   parameter int PRESCALE = 4,
   parameter int BLANK    = 1
) (
   input  logic                     CLK,
   input  logic                     RST_L,
   input  logic                     G_L,
   input  logic                     SCAN,
   input  logic [SEL_W-1:0]         SEL,
   output logic [(1<<SEL_W)-1:0]    Y_L,
   output logic [SEL_W-1:0]         IDX,
   output logic                     WRAP
);

   localparam int N    = 1 << SEL_W;
   localparam int PC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PC_W-1:0] PC_MAX   = PC_W'(PRESCALE - 1);
   localparam logic [PC_W-1:0] BLANK_PC = PC_W'(BLANK);
   localparam logic [N-1:0]    ONE      = N'(1);

   if (PRESCALE < 2) begin : g_bad_prescale
      $error("scan_decoder_l: PRESCALE must be at least 2");
   end
   if (BLANK >= PRESCALE || BLANK < 0) begin : g_bad_blank
      $error("scan_decoder_l: BLANK must lie in 0 .. PRESCALE-1");
   end

   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  pc_next;
   logic [SEL_W-1:0] idx_next;
   logic             wrap_next;
   logic             in_blank;
   logic [N-1:0]     y_next;

   always_comb begin
      pc_next   = pc;
      idx_next  = IDX;
      wrap_next = 1'b0;
      if (!G_L) begin
         if (!SCAN) begin
            pc_next  = '0;
            idx_next = SEL;
         end else if (pc == PC_MAX) begin
            pc_next   = '0;
            idx_next  = IDX + 1'b1;
            wrap_next = &IDX;
         end else begin
            pc_next = pc + 1'b1;
         end
      end
   end

   // Blanking looks at the counter value the index will have after this edge.
   if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
   end else begin : g_blank
      assign in_blank = (pc_next < BLANK_PC);
   end

   always_comb begin
      y_next = '1;
      if (!G_L && !(SCAN && in_blank)) begin
         y_next = ~(ONE << idx_next);
      end
   end

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         pc   <= '0;
         IDX  <= '0;
         Y_L  <= '1;
         WRAP <= 1'b0;
      end else begin
         pc   <= pc_next;
         IDX  <= idx_next;
         Y_L  <= y_next;
         WRAP <= wrap_next;
      end
   end

endmodule
